adc_sensor_scan: RTL

Front-end sequencer for the on-board ADC128S022 8-channel serial ADC. It continuously scans channels 0, 1 and 2 over the SPI-style interface and presents three 12-bit results to the line-following controller. It also pulses a strobe each time a complete, coherent set of all three channels has been updated. The block sits directly upstream of the line follower: its `ch0..ch2` outputs drive that controller's three sensor inputs.

---
 rtl/adc_sensor_pkg.sv | 22 ++
 rtl/adc_sensor_scan_sck_gen.sv | 47 ++++
 rtl/adc_sensor_scan.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/adc_sensor_pkg.sv
// Shared constants, types and FSM state encoding for the ADC128S022 scan sequencer.
package adc_sensor_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned ADDR_MSB   = 13;

    typedef logic [2:0] adc_addr_t;

    typedef logic [1:0] adc_state_t;
    localparam adc_state_t QUIET = 2'd0;
    localparam adc_state_t FRAME = 2'd1;
    localparam adc_state_t LATCH = 2'd2;

    function automatic adc_addr_t next_addr(input adc_addr_t addr, input int unsigned num_ch);
        if (addr == adc_addr_t'(num_ch - 1)) begin
            return '0;
        end
        return addr + 3'd1;
    endfunction

endpackage

// File: rtl/adc_sensor_scan_sck_gen.sv
// SCLK generator: low half then high half per period, edge strobes and a period counter.
module adc_sck_gen
    import adc_sensor_pkg::*;
#(
    parameter int unsigned SCK_HALF = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    output logic                          sck,
    output logic                          rise,
    output logic                          fall,
    output logic [$clog2(FRAME_BITS)-1:0] bit_cnt
);

    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    logic [7:0]       half_cnt_q;
    logic             phase_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic             half_end;

    assign half_end = (half_cnt_q == 8'(SCK_HALF - 1));

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            half_cnt_q <= '0;
            phase_q    <= 1'b0;
            bit_cnt_q  <= '0;
        end else if (half_end) begin
            half_cnt_q <= '0;
            phase_q    <= !phase_q;
            if (phase_q) begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
        end else begin
            half_cnt_q <= half_cnt_q + 8'd1;
        end
    end

    // Idle high whenever disabled, so a frame starts with the falling edge.
    assign sck     = !en || phase_q;
    assign rise    = en && !phase_q && half_end;
    assign fall    = en && phase_q && half_end;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/adc_sensor_scan.sv
// Continuous channel scan of the ADC128S022. ADC_SENSOR_AVG_EN enables 4-sample averaging
// and holds off set_valid until four complete sets have been collected.
module adc_sensor_scan
    import adc_sensor_pkg::*;
#(
    parameter int unsigned SCK_HALF = 10,
    parameter int unsigned NUM_CH   = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        adc_sck,
    output logic        adc_cs_n,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic [11:0] ch0,
    output logic [11:0] ch1,
    output logic [11:0] ch2,
    output logic        set_valid
);

    localparam int unsigned BIT_W     = $clog2(FRAME_BITS);
    localparam adc_addr_t   LAST_ADDR = adc_addr_t'(NUM_CH - 1);
    localparam logic [8:0]  QUIET_END = 9'(2 * SCK_HALF - 1);

    adc_state_t            state_q, state_d;
    logic [8:0]            quiet_cnt_q;
    adc_addr_t             addr_q, prev_addr_q;
    logic                  first_q;
    logic [FRAME_BITS-1:0] tx_q, rx_q, tx_word;
    logic                  set_valid_q;

    logic                  sck_en, sck_rise, sck_fall;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  quiet_done, frame_done, wr_en, set_done;
    logic [DATA_BITS-1:0]  wr_data;
    logic                  rx_hi_unused;

    assign sck_en = (state_q == FRAME);

    adc_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (sck_en),
        .sck     (adc_sck),
        .rise    (sck_rise),
        .fall    (sck_fall),
        .bit_cnt (bit_cnt)
    );

    always_comb begin
        tx_word                 = '0;
        tx_word[ADDR_MSB -: 3]  = addr_q;
    end

    assign quiet_done   = (state_q == QUIET) && (quiet_cnt_q == QUIET_END);
    assign frame_done   = sck_fall && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign wr_en        = (state_q == LATCH) && !first_q;
    assign set_done     = wr_en && (prev_addr_q == LAST_ADDR);
    assign wr_data      = rx_q[DATA_BITS-1:0];
    assign rx_hi_unused = ^rx_q[FRAME_BITS-1:DATA_BITS];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            QUIET:   if (quiet_done) state_d = FRAME;
            FRAME:   if (frame_done) state_d = LATCH;
            LATCH:   state_d = QUIET;
            default: state_d = QUIET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= QUIET;
            quiet_cnt_q <= '0;
            addr_q      <= '0;
            prev_addr_q <= '0;
            first_q     <= 1'b1;
            tx_q        <= '0;
            rx_q        <= '0;
        end else begin
            state_q     <= state_d;
            quiet_cnt_q <= (state_q == QUIET && !quiet_done) ? quiet_cnt_q + 9'd1 : 9'd0;
            if (quiet_done) begin
                tx_q <= tx_word;
            end else if (sck_fall) begin
                tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
            end
            if (sck_rise) begin
                rx_q <= {rx_q[FRAME_BITS-2:0], adc_dout};
            end
            if (state_q == LATCH) begin
                prev_addr_q <= addr_q;
                addr_q      <= next_addr(addr_q, NUM_CH);
                first_q     <= 1'b0;
            end
        end
    end

    // Chip select stays low through LATCH; only QUIET separates frames.
    assign adc_cs_n  = (state_q == QUIET);
    assign adc_din   = tx_q[FRAME_BITS-1];
    assign set_valid = set_valid_q;

`ifdef ADC_SENSOR_AVG_EN
    logic [DATA_BITS-1:0] hist_q [3][4];
    logic [13:0]          sum_q  [3];
    logic [2:0]           sets_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                sum_q[i] <= '0;
                for (int k = 0; k < 4; k++) begin
                    hist_q[i][k] <= '0;
                end
            end
            sets_q      <= '0;
            set_valid_q <= 1'b0;
        end else begin
            set_valid_q <= set_done && (sets_q >= 3'd3);
            if (set_done && sets_q != 3'd4) begin
                sets_q <= sets_q + 3'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (wr_en && prev_addr_q == adc_addr_t'(i)) begin
                    sum_q[i] <= sum_q[i] + 14'(wr_data) - 14'(hist_q[i][3]);
                    for (int k = 3; k > 0; k--) begin
                        hist_q[i][k] <= hist_q[i][k-1];
                    end
                    hist_q[i][0] <= wr_data;
                end
            end
        end
    end

    assign ch0 = sum_q[0][13:2];
    assign ch1 = sum_q[1][13:2];
    assign ch2 = sum_q[2][13:2];
`else
    logic [DATA_BITS-1:0] ch_q [3];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                ch_q[i] <= '0;
            end
            set_valid_q <= 1'b0;
        end else begin
            set_valid_q <= set_done;
            // Addresses beyond 2 match no slot and are dropped here.
            for (int i = 0; i < 3; i++) begin
                if (wr_en && prev_addr_q == adc_addr_t'(i)) begin
                    ch_q[i] <= wr_data;
                end
            end
        end
    end

    assign ch0 = ch_q[0];
    assign ch1 = ch_q[1];
    assign ch2 = ch_q[2];
`endif

endmodule
